dct_io_sequencer: RTL
=====================

# dct_io_sequencer

Synthesizable, parametrised row sequencer for the 2-D DCT datapath: fetches packed pixel rows from a synchronous row memory, presents them zero-extended to the DCT core with a valid strobe, and counts returned coefficient rows on the core's `ready`. It replaces the fixed 8-lane, fixed-count feed/capture logic with configurable lanes, widths and frame size, and adds start/done control, back-to-back frames, a drain watchdog and an optional output checksum.

## Interface
- `IN_W`, 8, pixel width per lane (unsigned)
- `OUT_W`, 18, coefficient width per lane
- `LANES`, 8, pixels per row / coefficients per output row
- `DATA_COUNT`, 8192, rows per frame (256×256/8); ≥ 2
- `ADDR_W`, 13, row-memory address width; 2^ADDR_W ≥ DATA_COUNT
- `TIMEOUT`, 64, max idle cycles in DRAIN between output rows; ≥ 2
- `clk  in  1  clock, rising edge`
- `rst_n  in  1  reset, asynchronous, active-low`
- `start  in  1  begin one frame; sampled only in IDLE`
- `mem_rd  out  1  row-memory read enable`
- `mem_addr  out  ADDR_W  row address`
- `mem_rdata  in  IN_W*LANES  row data, valid one cycle after mem_rd; lane 0 in MSBs`
- `x_bus  out  LANES*(IN_W+1)  pixels to DCT, each lane {1'b0, pixel}, lane 0 in MSBs`
- `x_valid  out  1  x_bus holds a frame row`
- `z_bus  in  LANES*OUT_W  coefficient row from DCT`
- `z_ready  in  1  z_bus valid this cycle`
- `busy  out  1  state ≠ IDLE`
- `done  out  1  one-cycle pulse at frame end`
- `timeout_err  out  1  sticky; set on watchdog expiry, cleared by next accepted start`
- `out_count  out  ADDR_W+1  output rows accepted this frame`
- `checksum  out  32  running output checksum (see Configuration)`

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: start=1 → FEED; mem_addr←0, mem_rd←1, out_count←0, timeout_err←0, checksum←0. start ignored in all other states.
- FEED: mem_addr increments each cycle; issuing address DATA_COUNT−1 → DRAIN next edge, mem_rd←0.
- Read pipeline: mem_rdata registered into x_bus with x_valid←1 one edge after data valid; x_valid drops after last row. x_bus holds last value when x_valid=0.
- z_ready counted in FEED and DRAIN only; z_ready in IDLE/DONE ignored. out_count saturates at DATA_COUNT; surplus z_ready ignored (no checksum update).
- DRAIN: watchdog counter clears on each accepted z_ready, else increments. out_count reaching DATA_COUNT → DONE. Watchdog = TIMEOUT → timeout_err←1, → DONE. Completion and expiry same edge: completion wins, no error.
- DONE: done=1 for exactly one cycle → IDLE. start in DONE ignored; next frame may start the cycle after done.
- Reset mid-frame: all state returns to reset values immediately; in-flight rows discarded.

## Timing
- Reset values: mem_rd=0, mem_addr=0, x_bus=0, x_valid=0, busy=0, done=0, timeout_err=0, out_count=0, checksum=0; state IDLE.
- start sampled at edge E: mem_rd=1, mem_addr=0 after E; mem_rdata row 0 after E+1; x_valid=1, x_bus=row 0 after E+2.
- Row k on x_bus after E+2+k; last x_valid cycle after E+DATA_COUNT+1.
- DRAIN entered after E+DATA_COUNT; done pulse one cycle after the edge that counts the final row.
- No combinational path from any input to any output.

## Configuration
- `DCT_IO_CHECKSUM_EN` defined: on each counted z_ready, checksum ← checksum + Σ lanes (each lane zero-extended to 32 bits), mod 2^32; cleared at accepted start; holds after done.
- Not defined: checksum constant 0, no adder logic synthesized.

## Test plan
- Reset: rst_n low mid-FEED (DATA_COUNT=4) → next cycle all outputs at reset values, state IDLE, busy=0.
- Basic frame, DATA_COUNT=4, LANES=8, rows 0x0001020304050607+k, DCT model z_ready 3 cycles after each x_valid → x_bus lane0 = 9'h000..., four x_valid cycles starting E+2, out_count=4, done pulse one cycle, timeout_err=0.
- Watchdog, TIMEOUT=8, model returns only 3 of 4 rows → timeout_err=1 and done exactly 8 idle DRAIN cycles after last z_ready; out_count=3.
- Start ignored while busy, plus back-to-back: start held high continuously → second frame begins the cycle after done, mem_addr restarts at 0, out_count resets.
- Surplus/idle z_ready: z_ready pulsed in IDLE and a 5th z_ready in frame of 4 → out_count stays 0 / 4, checksum unchanged.
- Checksum (macro defined): 4 output rows, every lane = 18'h00010 → checksum = 4×8×16 = 0x200; macro undefined → checksum = 0.

Source files
------------

// File: rtl/dct_io_sequencer.sv
// rtl/dct_io_sequencer.sv - DCT row feed/capture sequencer; optional checksum via DCT_IO_CHECKSUM_EN
`timescale 1ns/1ps

module dct_io_sequencer #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 18,
    parameter int LANES      = 8,
    parameter int DATA_COUNT = 8192,
    parameter int ADDR_W     = 13,
    parameter int TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         mem_rd,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [IN_W*LANES-1:0]        mem_rdata,
    output logic [LANES*(IN_W+1)-1:0]    x_bus,
    output logic                         x_valid,
    input  logic [LANES*OUT_W-1:0]       z_bus,
    input  logic                         z_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout_err,
    output logic [ADDR_W:0]              out_count,
    output logic [31:0]                  checksum
);

    localparam int                WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]   COUNT_MAX  = (ADDR_W + 1)'(DATA_COUNT);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DATA_COUNT - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic                        mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic                        err_q, err_d;
    logic [ADDR_W:0]             out_count_q, out_count_d;
    logic [WD_W-1:0]             wd_q, wd_d;
    logic                        accept;
    logic                        frame_clear;

    logic                        rd_pend_q;
    logic [LANES*(IN_W+1)-1:0]   x_bus_q, x_bus_d;
    logic                        x_valid_q;

    // Next-state logic: frame control, row counting and drain watchdog
    always_comb begin
        state_d     = state_q;
        mem_rd_d    = mem_rd_q;
        mem_addr_d  = mem_addr_q;
        err_d       = err_q;
        out_count_d = out_count_q;
        wd_d        = wd_q;
        frame_clear = 1'b0;

        // Rows are only counted while a frame is active and not yet complete
        accept = z_ready && (state_q == S_FEED || state_q == S_DRAIN) &&
                 (out_count_q != COUNT_MAX);
        if (accept) begin
            out_count_d = out_count_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FEED;
                    mem_rd_d    = 1'b1;
                    mem_addr_d  = '0;
                    out_count_d = '0;
                    err_d       = 1'b0;
                    wd_d        = '0;
                    frame_clear = 1'b1;
                end
            end
            S_FEED: begin
                if (mem_addr_q == LAST_ADDR) begin
                    state_d  = S_DRAIN;
                    mem_rd_d = 1'b0;
                end else begin
                    mem_addr_d = mem_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
                // Completion takes priority over a watchdog expiry on the same edge
                if (out_count_d == COUNT_MAX) begin
                    state_d = S_DONE;
                end else if (!accept && wd_d == WD_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            err_q       <= 1'b0;
            out_count_q <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            err_q       <= err_d;
            out_count_q <= out_count_d;
            wd_q        <= wd_d;
        end
    end

    // Zero-extend each pixel lane; lane order is preserved (lane 0 in MSBs)
    always_comb begin
        x_bus_d = '0;
        for (int i = 0; i < LANES; i++) begin
            x_bus_d[i*(IN_W+1) +: (IN_W+1)] = {1'b0, mem_rdata[i*IN_W +: IN_W]};
        end
    end

    // Read pipeline: memory data lands one cycle after mem_rd, then is registered onto x_bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            x_bus_q   <= '0;
            x_valid_q <= 1'b0;
        end else begin
            rd_pend_q <= mem_rd_q;
            x_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                x_bus_q <= x_bus_d;
            end
        end
    end

`ifdef DCT_IO_CHECKSUM_EN
    logic [31:0] lane_sum;
    logic [31:0] checksum_q;

    // Sum of all coefficient lanes of the current row, each zero-extended
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + 32'(z_bus[i*OUT_W +: OUT_W]);
        end
    end

    // Running checksum over accepted rows, cleared when a frame starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (frame_clear) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q + lane_sum;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_z;
    assign unused_z = ^{z_bus, frame_clear};
    assign checksum = 32'd0;
`endif

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign x_bus       = x_bus_q;
    assign x_valid     = x_valid_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign timeout_err = err_q;
    assign out_count   = out_count_q;

endmodule
